// File: rtl/data_shift_sampler.sv
// Registered 24->8 bit signed sample converter with enable and decimation.
// Define DATA_SHIFT_SAMPLER_ROUND_EN for round-half-up with saturation instead of floor.
module data_shift_sampler #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 8,
  parameter int DECIM = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enn,
  input  logic signed [IN_W-1:0]  data_in,
  output logic signed [OUT_W-1:0] data_out
);

  localparam int         SHIFT = IN_W - OUT_W;
  localparam logic [7:0] LAST  = 8'(DECIM - 1);

`ifdef DATA_SHIFT_SAMPLER_ROUND_EN
  localparam logic signed [IN_W:0] HALF = {{(OUT_W + 1){1'b0}}, 1'b1, {(SHIFT - 1){1'b0}}};

  // One guard bit keeps the +half from wrapping; only the positive side can overflow.
  function automatic logic signed [OUT_W-1:0] convert(input logic signed [IN_W-1:0] s);
    logic signed [IN_W:0] sum;
    sum = {s[IN_W-1], s} + HALF;
    if (!sum[IN_W] && sum[IN_W-1])
      return {1'b0, {(OUT_W - 1){1'b1}}};
    return OUT_W'(sum >>> SHIFT);
  endfunction
`else
  function automatic logic signed [OUT_W-1:0] convert(input logic signed [IN_W-1:0] s);
    return OUT_W'(s >>> SHIFT);
  endfunction
`endif

  logic [7:0]              cnt_q, cnt_d;
  logic signed [OUT_W-1:0] data_q, data_d;
  logic                    tick;

  assign tick = enn && (cnt_q == LAST);

  always_comb begin
    cnt_d  = cnt_q;
    data_d = data_q;
    if (tick) begin
      cnt_d  = '0;
      data_d = convert(data_in);
    end else if (enn) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
    end
  end

  assign data_out = data_q;

endmodule

// File: tb/tb_data_shift_sampler.sv
// Directed bench for data_shift_sampler: one DECIM=1 instance and one DECIM=4 instance.
module tb_data_shift_sampler;

  logic               clk = 1'b0;
  logic               rst;
  logic               enn;
  logic signed [23:0] data_in;
  logic signed [7:0]  out1;
  logic signed [7:0]  out4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_shift_sampler #(.IN_W(24), .OUT_W(8), .DECIM(1)) u_d1 (
    .clk(clk), .rst(rst), .enn(enn), .data_in(data_in), .data_out(out1)
  );

  data_shift_sampler #(.IN_W(24), .OUT_W(8), .DECIM(4)) u_d4 (
    .clk(clk), .rst(rst), .enn(enn), .data_in(data_in), .data_out(out4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enn = 1'b1; data_in = 24'h123456;
    step(); step();
    n_cmp++;
    if (out1 !== 8'h00) begin
      n_bad++; $display("FAIL reset_d1 got %h want 00", out1);
    end
    n_cmp++;
    if (out4 !== 8'h00) begin
      n_bad++; $display("FAIL reset_d4 got %h want 00", out4);
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if (out1 !== 8'h12) begin
      n_bad++; $display("FAIL reset_release got %h want 12", out1);
    end
  endtask

  task automatic apply_d1(input logic [23:0] din, input logic [7:0] exp, input string name);
    data_in = din;
    step();
    n_cmp++;
    if (out1 !== exp) begin
      n_bad++; $display("FAIL %s in=%h got %h want %h", name, din, out1, exp);
    end
  endtask

`ifndef DATA_SHIFT_SAMPLER_ROUND_EN
  task automatic test_truncation();
    enn = 1'b1;
    apply_d1(24'h010000, 8'h01, "trunc_65536");
    apply_d1(24'h020000, 8'h02, "trunc_131072");
    apply_d1(24'h040000, 8'h04, "trunc_262144");
    apply_d1(24'hFD0000, 8'hFD, "trunc_m196608");
  endtask

  task automatic test_extremes();
    enn = 1'b1;
    apply_d1(24'h7FFFFF, 8'h7F, "ext_max");
    apply_d1(24'h800000, 8'h80, "ext_min");
    apply_d1(24'hFFFFFF, 8'hFF, "ext_m1");
    apply_d1(24'h00FFFF, 8'h00, "ext_low");
  endtask
`else
  task automatic test_rounding();
    enn = 1'b1;
    apply_d1(24'h018000, 8'h02, "rnd_half_up");
    apply_d1(24'h017FFF, 8'h01, "rnd_below_half");
    apply_d1(24'h7FFFFF, 8'h7F, "rnd_sat_max");
    apply_d1(24'h7F8000, 8'h7F, "rnd_sat_7f8000");
    apply_d1(24'hFD0000, 8'hFD, "rnd_m196608");
    apply_d1(24'hFF8000, 8'h00, "rnd_m32768");
    apply_d1(24'h800000, 8'h80, "rnd_min");
  endtask
`endif

  task automatic test_enable_hold();
    enn = 1'b1;
    apply_d1(24'h050000, 8'h05, "hold_load");
    enn = 1'b0;
    for (int i = 0; i < 5; i++) apply_d1(24'h200000, 8'h05, "hold_frozen");
    enn = 1'b1;
    apply_d1(24'h200000, 8'h20, "hold_resume");
  endtask

  task automatic test_decimation();
    logic [7:0] exp;
    rst = 1'b1; enn = 1'b1; data_in = '0;
    step();
    rst = 1'b0;
    exp = 8'h00;
    // Ramp 0x00..0x0D: ticks land on inputs 3, 7, 11.
    for (int i = 0; i < 14; i++) begin
      data_in = 24'(i) << 16;
      if (i % 4 == 3) exp = 8'(i);
      step();
      n_cmp++;
      if (out4 !== exp) begin
        n_bad++; $display("FAIL decim_ramp i=%0d got %h want %h", i, out4, exp);
      end
    end
    // Counter sits at 2 here; a gap must freeze it, not restart it.
    enn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_in = 24'h300000;
      step();
      n_cmp++;
      if (out4 !== 8'h0B) begin
        n_bad++; $display("FAIL decim_gap got %h want 0b", out4);
      end
    end
    enn = 1'b1;
    data_in = 24'h0E0000;
    step();
    n_cmp++;
    if (out4 !== 8'h0B) begin
      n_bad++; $display("FAIL decim_resume_nontick got %h want 0b", out4);
    end
    data_in = 24'h0F0000;
    step();
    n_cmp++;
    if (out4 !== 8'h0F) begin
      n_bad++; $display("FAIL decim_resume_tick got %h want 0f", out4);
    end
  endtask

  task automatic test_reset_midrun();
    enn = 1'b1;
    data_in = 24'h010000; step();
    data_in = 24'h020000; step();
    rst = 1'b1; data_in = 24'h400000;
    step();
    n_cmp++;
    if (out4 !== 8'h00 || out1 !== 8'h00) begin
      n_bad++; $display("FAIL midrun_reset got %h/%h want 00/00", out1, out4);
    end
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      data_in = 24'(8'h40 + i) << 16;
      step();
      n_cmp++;
      if (out4 !== ((i == 4) ? 8'h44 : 8'h00)) begin
        n_bad++; $display("FAIL midrun_first_tick i=%0d got %h want %h", i, out4,
                          (i == 4) ? 8'h44 : 8'h00);
      end
    end
  endtask

  initial begin
    rst = 1'b1; enn = 1'b0; data_in = '0;
    test_reset();
`ifndef DATA_SHIFT_SAMPLER_ROUND_EN
    test_truncation();
    test_extremes();
`else
    test_rounding();
`endif
    test_enable_hold();
    test_decimation();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
